// File: rtl/silife_pkg.sv
// rtl/silife_pkg.sv - shared life-display constants and types
package silife_pkg;

  localparam int SILIFE_WIDTH    = 32;
  localparam int SILIFE_HEIGHT   = 32;
  localparam int SILIFE_ROW_BITS = $clog2(SILIFE_HEIGHT);

  typedef logic [SILIFE_ROW_BITS-1:0] row_t;

  // FILL: writer owns the back bank; WAIT_SWAP: committed, waiting for a frame boundary
  typedef enum logic {
    FB_FILL      = 1'b0,
    FB_WAIT_SWAP = 1'b1
  } fb_state_e;

endpackage

// File: rtl/silife_frame_buffer_if.sv
// rtl/silife_frame_buffer_if.sv - writer/reader port bundle of the frame buffer
interface silife_frame_buffer_if
  import silife_pkg::*;
#(
  parameter int WIDTH  = SILIFE_WIDTH,
  parameter int HEIGHT = SILIFE_HEIGHT
);
  localparam int ROW_BITS = $clog2(HEIGHT);

  logic                i_wr_en;
  logic [ROW_BITS-1:0] i_wr_row;
  logic [WIDTH-1:0]    i_wr_data;
  logic                i_wr_commit;
  logic                o_wr_ready;
  logic [ROW_BITS-1:0] i_rd_row;
  logic [WIDTH-1:0]    o_rd_cells;
  logic                i_rd_idle;
  logic                o_swap_pending;
  logic [7:0]          o_frame_count;

  modport master (
    output i_wr_en, i_wr_row, i_wr_data, i_wr_commit, i_rd_row, i_rd_idle,
    input  o_wr_ready, o_rd_cells, o_swap_pending, o_frame_count
  );

  modport slave (
    input  i_wr_en, i_wr_row, i_wr_data, i_wr_commit, i_rd_row, i_rd_idle,
    output o_wr_ready, o_rd_cells, o_swap_pending, o_frame_count
  );

endinterface

// File: rtl/silife_row_bank.sv
// rtl/silife_row_bank.sv - one HEIGHT x WIDTH flop bank, sync write, comb read
module silife_row_bank #(
  parameter int WIDTH    = 32,
  parameter int HEIGHT   = 32,
  parameter int ROW_BITS = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ROW_BITS-1:0] wr_row,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ROW_BITS-1:0] rd_row,
  output logic [WIDTH-1:0]    rd_data
);

  logic [WIDTH-1:0] mem [HEIGHT];
  logic             wr_in_range;
  logic             rd_in_range;

  // Row indices past HEIGHT only exist for non-power-of-2 heights
  assign wr_in_range = {1'b0, wr_row} < (ROW_BITS+1)'(HEIGHT);
  assign rd_in_range = {1'b0, rd_row} < (ROW_BITS+1)'(HEIGHT);

  // Row storage: cleared on reset, one row written per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HEIGHT; i++) mem[i] <= '0;
    end else if (wr_en && wr_in_range) begin
      mem[wr_row] <= wr_data;
    end
  end

  assign rd_data = rd_in_range ? mem[rd_row] : '0;

endmodule

// File: rtl/silife_frame_buffer.sv
// rtl/silife_frame_buffer.sv - double-buffered cell store swapped at display frame boundaries
module silife_frame_buffer
  import silife_pkg::*;
#(
  parameter int WIDTH  = SILIFE_WIDTH,
  parameter int HEIGHT = SILIFE_HEIGHT
) (
  input logic                  clk,
  input logic                  reset,
  silife_frame_buffer_if.slave bus
);

  localparam int ROW_BITS = $clog2(HEIGHT);

  fb_state_e           state;
  fb_state_e           state_next;
  logic                front;
  logic [7:0]          frame_count;
  logic [ROW_BITS-1:0] prev_row;
  logic                boundary;
  logic                wr_ready;
  logic                pending;
  logic                do_swap;
  logic                write_ok;
  logic                commit_ok;
  logic [WIDTH-1:0]    rd_bank0;
  logic [WIDTH-1:0]    rd_bank1;

  // Display wrapped to row 0 (new frame) or is not scanning at all
  assign boundary  = (bus.i_rd_row == '0 && prev_row != '0) || bus.i_rd_idle;
  assign write_ok  = bus.i_wr_en && wr_ready;
  assign commit_ok = bus.i_wr_commit && wr_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FB_FILL;
    else       state <= state_next;
  end

  // Next state: commit arms the swap, a boundary while armed completes it
  always_comb begin
    state_next = state;
    case (state)
      FB_FILL:      if (commit_ok) state_next = FB_WAIT_SWAP;
      FB_WAIT_SWAP: if (boundary)  state_next = FB_FILL;
      default:      state_next = FB_FILL;
    endcase
  end

  // Outputs: a commit landing on a boundary cycle is still FILL, so it cannot swap that cycle
  always_comb begin
    wr_ready = 1'b0;
    pending  = 1'b0;
    do_swap  = 1'b0;
    case (state)
      FB_FILL:      wr_ready = 1'b1;
      FB_WAIT_SWAP: begin
        pending = 1'b1;
        do_swap = boundary;
      end
      default:      wr_ready = 1'b1;
    endcase
  end

  // Bank select, generation counter and row history for boundary detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front       <= 1'b0;
      frame_count <= '0;
      prev_row    <= '0;
    end else begin
      prev_row <= bus.i_rd_row;
      if (do_swap) begin
        front       <= ~front;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  silife_row_bank #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_BITS(ROW_BITS)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (write_ok && front),
    .wr_row  (bus.i_wr_row),
    .wr_data (bus.i_wr_data),
    .rd_row  (bus.i_rd_row),
    .rd_data (rd_bank0)
  );

  silife_row_bank #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ROW_BITS(ROW_BITS)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (write_ok && !front),
    .wr_row  (bus.i_wr_row),
    .wr_data (bus.i_wr_data),
    .rd_row  (bus.i_rd_row),
    .rd_data (rd_bank1)
  );

  assign bus.o_rd_cells     = front ? rd_bank1 : rd_bank0;
  assign bus.o_wr_ready     = wr_ready;
  assign bus.o_swap_pending = pending;
  assign bus.o_frame_count  = frame_count;

endmodule
